calc_key_entry: RTL and testbench
=================================

# calc_key_entry

Key-entry stage directly downstream of the keypad scanner. Consumes the scanner's one-hot `{rows,cols}` key code through the `done`/`ack` handshake and decodes it into a digit, operator, clear or equals. It assembles two binary operands and an opcode from digit sequences, then presents them to the arithmetic unit with a `calc_req`/`calc_ack` handshake.

## Interface
Parameters:
- `ROWS`, default 4: keypad rows; must match the scanner.
- `COLS`, default 4: keypad columns; must match the scanner.
- `MAX_DIGITS`, default 4: maximum decimal digits per operand.
- `OPW`, default 16: operand width. Must satisfy 2^OPW > 10^MAX_DIGITS − 1.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `key_done` in 1: scanner `done`; `key_data` is valid while high.
- `key_data` in ROWS+COLS: scanner data, `{rows,cols}`.
- `key_ack` out 1: one-cycle acknowledge to the scanner.
- `key_err` out 1: one-cycle pulse when `key_data` is not one-hot in both halves.
- `entry` out OPW: value of the operand currently being typed, for display.
- `operand_a` out OPW: first operand.
- `operand_b` out OPW: second operand.
- `opcode` out 2: operator. 0=ADD, 1=SUB, 2=MUL, 3=DIV.
- `calc_req` out 1: operands and opcode are valid; held until acknowledged.
- `calc_ack` in 1: arithmetic unit accepts the request.

## Operation
- **Key map** (row r, col c, index r*4+c):
  - row0: 1, 2, 3, +
  - row1: 4, 5, 6, −
  - row2: 7, 8, 9, ×
  - row3: C, 0, =, ÷
- **Accept condition:** `key_done`=1, `key_ack`=0 and state≠ISSUE.
- **On accept:**
  - The key is decoded and applied on the same edge.
  - `key_ack`=1 for exactly the next cycle.
  - Invalid codes are still acked. They pulse `key_err` together with `key_ack` and have no other effect.
- **FSM states:** ENTER_A, ENTER_B, ISSUE.
- **Digit** (ENTER_A or ENTER_B):
  - acc ← acc*10 + d, computed as (acc<<3)+(acc<<1)+d.
  - Applied only if digit count < MAX_DIGITS; otherwise the digit is ignored (still acked).
  - Leading zeros count as digits.
- **Operator:**
  - ENTER_A with ≥1 digit: `operand_a`←acc, `opcode`←op, acc←0, count←0, go to ENTER_B.
  - ENTER_A with 0 digits: ignored.
  - ENTER_B with 0 digits: replaces `opcode`.
  - ENTER_B with ≥1 digit: ignored.
- **Equals:**
  - ENTER_B with ≥1 digit: `operand_b`←acc, go to ISSUE.
  - Otherwise ignored.
- **Clear:** in ENTER_A or ENTER_B, clears acc, count, `operand_a`, `operand_b` and `opcode`, and returns to ENTER_A.
- **ISSUE:**
  - `calc_req`=1, with operands and opcode stable.
  - Keys are not acked, so the scanner stalls holding its key.
  - On an edge with `calc_ack`=1: `calc_req`←0, acc←0, count←0, go to ENTER_A. Operands keep their last values.
- **Display:** `entry` = acc in ENTER_A/ENTER_B; `operand_b` in ISSUE.

## Timing
- **Reset values:** state=ENTER_A; `key_ack`, `key_err`, `calc_req`, `entry`, operands and `opcode` all 0. Reset takes effect immediately and asynchronously, including mid-handshake (an ack is dropped) or in ISSUE (the request is dropped).
- **Key latency:** accept at edge T; `key_ack` and `entry` update after T; `key_ack` falls after T+1.
- **No double capture:** no accept is possible while `key_ack`=1. A key held down yields exactly one accept, because the scanner waits for release.
- **Request latency:** `calc_req` rises the cycle after the equals accept.
- **Back-to-back acknowledge:** `calc_ack` high on the first `calc_req` cycle is honoured (one-cycle request).
- **`calc_ack` outside ISSUE:** ignored.
- **All outputs registered.** None depend combinationally on inputs.

## Structure
- **Shared package `calc_pkg`:**
  - `opcode_e` (ADD/SUB/MUL/DIV).
  - `key_kind_e` (DIGIT, OP, CLEAR, EQUALS, INVALID).
  - The 16-entry key map constant.
  - State enum (ENTER_A, ENTER_B, ISSUE).
- **Sub-module `key_code_decoder`:** combinational; `{rows,cols}` → kind, digit[3:0], opcode. Includes the one-hot check. Reused by the verification model.

## Test plan
- Keys 1,2,+,3,4,= → `operand_a`=12, `operand_b`=34, `opcode`=ADD, `calc_req`=1; `calc_ack` pulse → `calc_req`=0, `entry`=0, state ENTER_A.
- Keys 9,8,7,6,5 with MAX_DIGITS=4 → `entry`=9876; five `key_ack` pulses; the fifth digit is ignored.
- Key 7, then `key_data`=8'b0011_0001 → `key_ack` and `key_err` pulse together; `entry` stays 7.
- Keys 5,−,×,2,= → `opcode`=MUL; keys +,= with 0 B digits → ignored (`key_ack` pulses only).
- In ISSUE, `key_done`=1 held for 10 cycles with no `calc_ack` → `key_ack` stays 0; after `calc_ack` the key is accepted one cycle later.
- `rst` pulled low asynchronously mid-cycle during ISSUE → `calc_req`, operands and `entry` go to 0 immediately; key 3 after release → `entry`=3.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared types and the keypad key map for the calculator key-entry
// stage and its verification model.
//   opcode_e    - arithmetic operator (ADD/SUB/MUL/DIV), encoded 0..3
//   key_kind_e  - decoded key class
//   key_info_t  - one key-map entry: kind, digit value, operator
//   KEY_MAP     - 16-entry map indexed by row*4 + col
//   state_e     - key-entry FSM states
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } opcode_e;

  typedef enum logic [2:0] {
    K_DIGIT   = 3'd0,
    K_OP      = 3'd1,
    K_CLEAR   = 3'd2,
    K_EQUALS  = 3'd3,
    K_INVALID = 3'd4
  } key_kind_e;

  typedef struct packed {
    key_kind_e  kind;
    logic [3:0] digit;
    opcode_e    op;
  } key_info_t;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ISSUE   = 2'd2
  } state_e;

  // Layout:  1 2 3 +  /  4 5 6 -  /  7 8 9 x  /  C 0 = /
  localparam key_info_t [0:15] KEY_MAP = '{
    '{K_DIGIT,  4'd1, OP_ADD}, '{K_DIGIT,  4'd2, OP_ADD},
    '{K_DIGIT,  4'd3, OP_ADD}, '{K_OP,     4'd0, OP_ADD},
    '{K_DIGIT,  4'd4, OP_ADD}, '{K_DIGIT,  4'd5, OP_ADD},
    '{K_DIGIT,  4'd6, OP_ADD}, '{K_OP,     4'd0, OP_SUB},
    '{K_DIGIT,  4'd7, OP_ADD}, '{K_DIGIT,  4'd8, OP_ADD},
    '{K_DIGIT,  4'd9, OP_ADD}, '{K_OP,     4'd0, OP_MUL},
    '{K_CLEAR,  4'd0, OP_ADD}, '{K_DIGIT,  4'd0, OP_ADD},
    '{K_EQUALS, 4'd0, OP_ADD}, '{K_OP,     4'd0, OP_DIV}
  };

endpackage

// File: rtl/key_code_decoder.sv
// key_code_decoder: combinational decode of the scanner's {rows,cols} code.
//   key_data_i  in  ROWS+COLS  one-hot row half (upper) and column half (lower)
//   kind_o      out            key class; K_INVALID unless both halves one-hot
//   digit_o     out 4          digit value for K_DIGIT
//   op_o        out 2          operator for K_OP
module key_code_decoder
  import calc_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic [ROWS+COLS-1:0] key_data_i,
  output key_kind_e            kind_o,
  output logic [3:0]           digit_o,
  output opcode_e              op_o
);

  logic [ROWS-1:0] rows;
  logic [COLS-1:0] cols;
  logic            rows_ok;
  logic            cols_ok;
  int              r_idx;
  int              c_idx;
  int              k_idx;
  key_info_t       info;

  assign rows = key_data_i[ROWS+COLS-1:COLS];
  assign cols = key_data_i[COLS-1:0];

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign rows_ok = (rows != '0) && ((rows & (rows - ROWS'(1))) == '0);
  assign cols_ok = (cols != '0) && ((cols & (cols - COLS'(1))) == '0);

  always_comb begin
    r_idx = 0;
    c_idx = 0;
    for (int i = 0; i < ROWS; i++) if (rows[i]) r_idx = i;
    for (int i = 0; i < COLS; i++) if (cols[i]) c_idx = i;
    k_idx = r_idx * COLS + c_idx;
    info  = '{K_INVALID, 4'd0, OP_ADD};
    // Positions beyond the 16-entry map (larger keypads) decode as invalid.
    if (rows_ok && cols_ok && k_idx < 16) info = KEY_MAP[k_idx[3:0]];
  end

  assign kind_o  = info.kind;
  assign digit_o = info.digit;
  assign op_o    = info.op;

endmodule

// File: rtl/calc_key_entry.sv
// calc_key_entry: turns scanner key codes into two decimal operands and an
// operator, then requests a calculation from the arithmetic unit.
//   clk, rst            clock; asynchronous active-low reset
//   key_done/key_data   scanner handshake in ({rows,cols} code)
//   key_ack, key_err    one-cycle acknowledge / invalid-code pulse
//   entry               operand being typed (operand_b while issuing)
//   operand_a/b, opcode assembled calculation
//   calc_req/calc_ack   request to the arithmetic unit
module calc_key_entry
  import calc_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int MAX_DIGITS = 4,
  parameter int OPW        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_done,
  input  logic [ROWS+COLS-1:0] key_data,
  output logic                 key_ack,
  output logic                 key_err,
  output logic [OPW-1:0]       entry,
  output logic [OPW-1:0]       operand_a,
  output logic [OPW-1:0]       operand_b,
  output logic [1:0]           opcode,
  output logic                 calc_req,
  input  logic                 calc_ack
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_e         state_q;
  logic [OPW-1:0] acc_q;
  logic [CW-1:0]  cnt_q;
  logic [OPW-1:0] operand_a_q;
  logic [OPW-1:0] operand_b_q;
  opcode_e        opcode_q;
  logic           key_ack_q;
  logic           key_err_q;
  logic           calc_req_q;
  logic [OPW-1:0] entry_q;

  key_kind_e      dec_kind;
  logic [3:0]     dec_digit;
  opcode_e        dec_op;
  logic [OPW-1:0] acc_mac_d;

  key_code_decoder #(.ROWS(ROWS), .COLS(COLS)) u_dec (
    .key_data_i (key_data),
    .kind_o     (dec_kind),
    .digit_o    (dec_digit),
    .op_o       (dec_op)
  );

  // acc*10 + d without a multiplier.
  assign acc_mac_d = (acc_q << 3) + (acc_q << 1) + OPW'(dec_digit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ENTER_A;
      acc_q       <= '0;
      cnt_q       <= '0;
      operand_a_q <= '0;
      operand_b_q <= '0;
      opcode_q    <= OP_ADD;
      key_ack_q   <= 1'b0;
      key_err_q   <= 1'b0;
      calc_req_q  <= 1'b0;
      entry_q     <= '0;
    end else begin
      key_ack_q <= 1'b0;
      key_err_q <= 1'b0;
      if (state_q == ISSUE) begin
        // Keys are left pending here; the scanner holds its code until acked.
        if (calc_ack) begin
          calc_req_q <= 1'b0;
          acc_q      <= '0;
          cnt_q      <= '0;
          entry_q    <= '0;
          state_q    <= ENTER_A;
        end
      end else if (key_done && !key_ack_q) begin
        key_ack_q <= 1'b1;
        case (dec_kind)
          K_DIGIT: begin
            if (cnt_q < CW'(MAX_DIGITS)) begin
              acc_q   <= acc_mac_d;
              cnt_q   <= cnt_q + CW'(1);
              entry_q <= acc_mac_d;
            end
          end
          K_OP: begin
            if (state_q == ENTER_A && cnt_q != '0) begin
              operand_a_q <= acc_q;
              opcode_q    <= dec_op;
              acc_q       <= '0;
              cnt_q       <= '0;
              entry_q     <= '0;
              state_q     <= ENTER_B;
            end else if (state_q == ENTER_B && cnt_q == '0) begin
              opcode_q <= dec_op;
            end
          end
          K_EQUALS: begin
            if (state_q == ENTER_B && cnt_q != '0) begin
              operand_b_q <= acc_q;
              entry_q     <= acc_q;  // display shows operand_b while issuing
              calc_req_q  <= 1'b1;
              state_q     <= ISSUE;
            end
          end
          K_CLEAR: begin
            acc_q       <= '0;
            cnt_q       <= '0;
            operand_a_q <= '0;
            operand_b_q <= '0;
            opcode_q    <= OP_ADD;
            entry_q     <= '0;
            state_q     <= ENTER_A;
          end
          default: key_err_q <= 1'b1;
        endcase
      end
    end
  end

  assign key_ack   = key_ack_q;
  assign key_err   = key_err_q;
  assign entry     = entry_q;
  assign operand_a = operand_a_q;
  assign operand_b = operand_b_q;
  assign opcode    = opcode_q;
  assign calc_req  = calc_req_q;

endmodule

// File: tb/tb_calc_key_entry.sv
module tb_calc_key_entry;

  localparam logic [7:0] K1 = 8'b0001_0001, K2 = 8'b0001_0010, K3 = 8'b0001_0100;
  localparam logic [7:0] KADD = 8'b0001_1000, K4 = 8'b0010_0001, K5 = 8'b0010_0010;
  localparam logic [7:0] K6 = 8'b0010_0100, KSUB = 8'b0010_1000, K7 = 8'b0100_0001;
  localparam logic [7:0] K8 = 8'b0100_0010, K9 = 8'b0100_0100, KMUL = 8'b0100_1000;
  localparam logic [7:0] KC = 8'b1000_0001, KEQ = 8'b1000_0100;
  localparam logic [7:0] KBAD = 8'b0011_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_done = 1'b0;
  logic [7:0]  key_data = 8'h00;
  logic        key_ack, key_err, calc_req;
  logic        calc_ack = 1'b0;
  logic [15:0] entry, operand_a, operand_b;
  logic [1:0]  opcode;

  calc_key_entry dut (
    .clk(clk), .rst(rst), .key_done(key_done), .key_data(key_data),
    .key_ack(key_ack), .key_err(key_err), .entry(entry),
    .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode),
    .calc_req(calc_req), .calc_ack(calc_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic err; logic [15:0] entry; } key_exp_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic [1:0] op; } req_exp_t;

  key_exp_t key_q[$];
  req_exp_t req_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scanner model: present a code, wait (bounded) for ack, then release.
  task automatic press(input logic [7:0] code, input logic err, input logic [15:0] ent);
    int n;
    key_q.push_back('{err, ent});
    key_done = 1'b1;
    key_data = code;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!key_ack && n < 20);
    if (!key_ack) chk("ack_timeout", 32'(key_ack), 32'd1);
    key_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_calc_ack();
    calc_ack = 1'b1;
    @(posedge clk); #1;
    calc_ack = 1'b0;
  endtask

  // Monitor: compares every key_ack pulse and every calc_req rise against the queues.
  logic req_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (key_ack) begin
        if (key_q.size() == 0) begin
          chk("unexpected_ack", 32'(key_ack), 32'd0);
        end else begin
          key_exp_t e;
          e = key_q.pop_front();
          chk("key_err", 32'(key_err), 32'(e.err));
          chk("entry", 32'(entry), 32'(e.entry));
        end
      end else if (key_err) begin
        chk("err_without_ack", 32'(key_err), 32'd0);
      end
      if (calc_req && !req_prev) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 32'(calc_req), 32'd0);
        end else begin
          req_exp_t r;
          r = req_q.pop_front();
          chk("operand_a", 32'(operand_a), 32'(r.a));
          chk("operand_b", 32'(operand_b), 32'(r.b));
          chk("opcode", 32'(opcode), 32'(r.op));
        end
      end
      req_prev = calc_req;
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ack", 32'(key_ack), 32'd0);
    chk("rst_key_err", 32'(key_err), 32'd0);
    chk("rst_calc_req", 32'(calc_req), 32'd0);
    chk("rst_entry", 32'(entry), 32'd0);
    chk("rst_operand_a", 32'(operand_a), 32'd0);
    chk("rst_operand_b", 32'(operand_b), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 12 + 34
    req_q.push_back('{16'd12, 16'd34, 2'd0});
    press(K1, 0, 1); press(K2, 0, 12); press(KADD, 0, 0);
    press(K3, 0, 3); press(K4, 0, 34); press(KEQ, 0, 34);
    chk("req_held", 32'(calc_req), 32'd1);
    pulse_calc_ack();
    chk("req_dropped", 32'(calc_req), 32'd0);
    chk("entry_after_ack", 32'(entry), 32'd0);
    $display("txn 12+34 done");

    // Digit limit: fifth digit ignored but acked.
    press(K9, 0, 9); press(K8, 0, 98); press(K7, 0, 987);
    press(K6, 0, 9876); press(K5, 0, 9876);
    press(KC, 0, 0);
    $display("txn digit limit done");

    // Invalid code leaves entry untouched.
    press(K7, 0, 7); press(KBAD, 1, 7); press(KC, 0, 0);
    $display("txn invalid code done");

    // Operator replacement, equals with no B digits ignored.
    req_q.push_back('{16'd5, 16'd2, 2'd2});
    press(K5, 0, 5); press(KSUB, 0, 0); press(KMUL, 0, 0);
    press(KEQ, 0, 0);
    chk("no_req_empty_b", 32'(calc_req), 32'd0);
    press(K2, 0, 2); press(KEQ, 0, 2);
    pulse_calc_ack();
    // Operator and equals in ENTER_A with no digits: ignored.
    press(KADD, 0, 0); press(KEQ, 0, 0);
    chk("op_a_kept", 32'(operand_a), 32'd5);
    chk("opcode_kept", 32'(opcode), 32'd2);
    chk("no_req_in_a", 32'(calc_req), 32'd0);
    $display("txn 5*2 done");

    // Stall in ISSUE: held key not acked until calc_ack.
    req_q.push_back('{16'd1, 16'd1, 2'd0});
    press(K1, 0, 1); press(KADD, 0, 0); press(K1, 0, 1); press(KEQ, 0, 1);
    key_done = 1'b1;
    key_data = K3;
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (key_ack) n++;
    end
    chk("stall_acks", 32'(n), 32'd0);
    chk("stall_entry", 32'(entry), 32'd1);
    key_q.push_back('{1'b0, 16'd3});
    pulse_calc_ack();
    chk("stall_ack_edge", 32'(key_ack), 32'd0);
    chk("stall_req_drop", 32'(calc_req), 32'd0);
    @(posedge clk); #1;
    chk("stall_accept", 32'(key_ack), 32'd1);
    key_done = 1'b0;
    @(posedge clk); #1;
    $display("txn stall done");

    // Asynchronous reset while issuing 3+4.
    req_q.push_back('{16'd3, 16'd4, 2'd0});
    press(KADD, 0, 0); press(K4, 0, 4); press(KEQ, 0, 4);
    chk("pre_rst_req", 32'(calc_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_calc_req", 32'(calc_req), 32'd0);
    chk("arst_operand_a", 32'(operand_a), 32'd0);
    chk("arst_operand_b", 32'(operand_b), 32'd0);
    chk("arst_entry", 32'(entry), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    press(K3, 0, 3);
    $display("txn async reset done");

    repeat (4) @(posedge clk);
    #1;
    chk("key_q_empty", 32'(key_q.size()), 32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1, "timeout");
  end

endmodule
